// File: rtl/warp_copy_engine_if.sv
// Bus bundle between the copy engine, the shared frame RAM and the warp stage.
// Handshake: there is no valid/ready pair. start is a level that the engine
// samples only while idle (ignored while busy); done is a one-cycle pulse;
// RAM read data and warp results are trusted purely by fixed latency, so the
// slave side must return ram_q / warp_out exactly RAM_RD_LAT / WARP_LAT cycles
// after it samples ram_addr / warp_i,warp_j.
interface warp_copy_engine_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [9:0]  warp_i;
    logic [9:0]  warp_j;
    logic [20:0] warp_out;
    logic        ram_we;
    logic [20:0] ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  ram_q;
    logic [18:0] skip_cnt;
    logic [2:0]  dbg_state;

    // Engine side
    modport master (
        input  start, warp_out, ram_q,
        output busy, done, warp_i, warp_j, ram_we, ram_addr, ram_data,
               skip_cnt, dbg_state
    );

    // Environment side (RAM, warp stage, controller)
    modport slave (
        output start, warp_out, ram_q,
        input  busy, done, warp_i, warp_j, ram_we, ram_addr, ram_data,
               skip_cnt, dbg_state
    );
endinterface

// File: rtl/warp_copy_engine.sv
// Frame remap sequencer: walks source pixels in raster order, reads each from
// the frame RAM, asks the warp stage for its destination offset and writes the
// pixel to DST_BASE + offset. Offsets outside the frame are counted, not written.
module warp_copy_engine #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 400000,
    parameter int RAM_RD_LAT = 1,
    parameter int WARP_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    warp_copy_engine_if.master bus
);

    // WAIT must cover the slower of the two pipelines, and at least one cycle.
    localparam int          L_RAW  = (RAM_RD_LAT > WARP_LAT) ? RAM_RD_LAT : WARP_LAT;
    localparam int          L      = (L_RAW < 1) ? 1 : L_RAW;
    localparam logic [20:0] SRC_A  = 21'(SRC_BASE);
    localparam logic [20:0] DST_A  = 21'(DST_BASE);
    localparam logic [20:0] NPIX   = 21'(WIDTH * HEIGHT);
    localparam logic [9:0]  J_LAST = 10'(WIDTH - 1);
    localparam logic [9:0]  I_LAST = 10'(HEIGHT - 1);
    localparam logic [7:0]  W_LAST = 8'(L - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_i, w_i_nxt;
    logic [9:0]  r_j, w_j_nxt;
    logic [18:0] r_k, w_k_nxt;
    logic [7:0]  r_wait, w_wait_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_ram_we, w_ram_we_nxt;
    logic [20:0] r_ram_addr, w_ram_addr_nxt;
    logic [7:0]  r_ram_data, w_ram_data_nxt;
    logic [9:0]  r_warp_i, w_warp_i_nxt;
    logic [9:0]  r_warp_j, w_warp_j_nxt;
    logic [18:0] r_skip, w_skip_nxt;

    logic w_last_pix;
    logic w_wait_last;
    logic w_in_range;

    assign w_last_pix  = (r_i == I_LAST) && (r_j == J_LAST);
    assign w_wait_last = (r_wait == W_LAST);
    assign w_in_range  = (bus.warp_out < NPIX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one pixel is READ, L x WAIT, WRITE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_READ;
            S_READ:   w_state_nxt = S_WAIT;
            S_WAIT:   if (w_wait_last) w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = w_last_pix ? S_FINISH : S_READ;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; computed on the transition into each
    // state so every output comes straight from a flop during that state.
    always_comb begin
        w_i_nxt        = r_i;
        w_j_nxt        = r_j;
        w_k_nxt        = r_k;
        w_wait_nxt     = r_wait;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_ram_we_nxt   = 1'b0;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_data_nxt = r_ram_data;
        w_warp_i_nxt   = r_warp_i;
        w_warp_j_nxt   = r_warp_j;
        w_skip_nxt     = r_skip;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_i_nxt        = 10'd0;
                    w_j_nxt        = 10'd0;
                    w_k_nxt        = 19'd0;
                    w_skip_nxt     = 19'd0;
                    w_busy_nxt     = 1'b1;
                    w_ram_addr_nxt = SRC_A;
                    w_warp_i_nxt   = 10'd0;
                    w_warp_j_nxt   = 10'd0;
                end
            end
            S_READ: begin
                w_wait_nxt = 8'd0;
            end
            S_WAIT: begin
                if (w_wait_last) begin
                    // Last WAIT cycle: pixel and offset are valid on the inputs now.
                    w_ram_data_nxt = bus.ram_q;
                    if (w_in_range) begin
                        w_ram_we_nxt   = 1'b1;
                        w_ram_addr_nxt = DST_A + bus.warp_out;
                    end else if (r_skip != '1) begin
                        w_skip_nxt = r_skip + 19'd1;
                    end
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            S_WRITE: begin
                if (w_last_pix) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end else begin
                    if (r_j == J_LAST) begin
                        w_j_nxt = 10'd0;
                        w_i_nxt = r_i + 10'd1;
                    end else begin
                        w_j_nxt = r_j + 10'd1;
                    end
                    w_k_nxt        = r_k + 19'd1;
                    w_ram_addr_nxt = SRC_A + {2'b00, r_k + 19'd1};
                    w_warp_i_nxt   = w_i_nxt;
                    w_warp_j_nxt   = w_j_nxt;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i        <= 10'd0;
            r_j        <= 10'd0;
            r_k        <= 19'd0;
            r_wait     <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= 21'd0;
            r_ram_data <= 8'd0;
            r_warp_i   <= 10'd0;
            r_warp_j   <= 10'd0;
            r_skip     <= 19'd0;
        end else begin
            r_i        <= w_i_nxt;
            r_j        <= w_j_nxt;
            r_k        <= w_k_nxt;
            r_wait     <= w_wait_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_data <= w_ram_data_nxt;
            r_warp_i   <= w_warp_i_nxt;
            r_warp_j   <= w_warp_j_nxt;
            r_skip     <= w_skip_nxt;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.warp_i    = r_warp_i;
    assign bus.warp_j    = r_warp_j;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_data  = r_ram_data;
    assign bus.skip_cnt  = r_skip;
    assign bus.dbg_state = r_state;

endmodule
